// File: rtl/wb_ram_slave.sv
// Wishbone classic-cycle RAM responder. It decodes a word-aligned address window and
// performs byte-selected reads and writes on an internal RAM. A fixed number of wait
// states is inserted before each response. Every request ends with exactly one
// registered ack or err pulse.
module wb_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdat_q, wdat_d;
  logic                  bad_q, bad_d;
  logic                  ack_d, err_d;
  logic [31:0]           rdat_d;
  logic                  mem_wr;
  logic                  req_hit, req_bad;

  assign req_hit = (wbs_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign req_bad = !req_hit || (wbs_addr_i[1:0] != 2'b00) || (wbs_sel_i == 4'b0000);

  // Next-state, request latching and registered-output decode.
  // The counter is loaded with WAIT_STATES, not WAIT_STATES-1, because every
  // request passes through WAIT at least once. That keeps RESP at T+1+WAIT_STATES
  // for all values, including zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    bad_d   = bad_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = wbs_dat_o;
    mem_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          idx_d   = wbs_addr_i[ADDR_WIDTH+1:2];
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          wdat_d  = wbs_dat_i;
          bad_d   = req_bad;
          cnt_d   = WS_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (bad_q) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (we_q) mem_wr = 1'b1;
            else      rdat_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request copy and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdat_q    <= '0;
      bad_q     <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      bad_q     <= bad_d;
      wbs_ack_o <= ack_d;
      wbs_err_o <= err_d;
      wbs_dat_o <= rdat_d;
    end
  end

  // Byte-lane RAM write. Reset on the commit edge discards the pending write.
  always_ff @(posedge clk_i) begin
    if (mem_wr && !rst_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave.
// Three instances are used: WAIT_STATES 1, 0 and 3, with a 64-word window at 0x1000.
module tb_wb_ram_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;

  logic        clk;
  logic        rst;
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [3:0]  sel  [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic        ack  [3];
  logic        err  [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_m [WORDS];
  logic [31:0] last_dat;

  wb_ram_slave #(.ADDR_WIDTH(6), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
    .wbs_sel_i(sel[0]), .wbs_addr_i(addr[0]), .wbs_dat_i(wdat[0]), .wbs_dat_o(rdat[0]),
    .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));

  wb_ram_slave #(.ADDR_WIDTH(6), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
    .wbs_sel_i(sel[1]), .wbs_addr_i(addr[1]), .wbs_dat_i(wdat[1]), .wbs_dat_o(rdat[1]),
    .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));

  wb_ram_slave #(.ADDR_WIDTH(6), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]), .wbs_we_i(we[2]),
    .wbs_sel_i(sel[2]), .wbs_addr_i(addr[2]), .wbs_dat_i(wdat[2]), .wbs_dat_o(rdat[2]),
    .wbs_ack_o(ack[2]), .wbs_err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: window/alignment/sel rules evaluated with plain arithmetic on byte addresses.
  task automatic model_step(input logic w, input logic [3:0] s, input logic [31:0] a,
                            input logic [31:0] dt, output logic e_ack, output logic e_err,
                            output logic [31:0] e_dat);
    bit bad;
    int idx;
    bad = (a < BASE) || (longint'(a) >= longint'(BASE) + 4 * WORDS) || (a % 4 != 0) || (s == 4'b0);
    e_err = bad;
    e_ack = !bad;
    e_dat = last_dat;
    if (!bad) begin
      idx = int'((a - BASE) / 4);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem_m[idx][8*b +: 8] = dt[8*b +: 8];
      end else begin
        e_dat    = mem_m[idx];
        last_dat = e_dat;
      end
    end
  endtask

  // One classic cycle. Inputs are scrambled after the sample edge, which shows
  // that the latched copy is what gets used.
  task automatic do_req(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] dt, output logic r_ack, output logic r_err,
                        output logic [31:0] r_dat, output int lat);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdat[d] = dt;
    @(posedge clk); #1;
    we[d] = ~w; sel[d] = ~s; addr[d] = ~a; wdat[d] = ~dt;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(ack[d] || err[d]) && lat < 20);
    r_ack = ack[d]; r_err = err[d]; r_dat = rdat[d];
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
    chk("pulse_width", {30'b0, ack[d], err[d]}, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] dat;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_dat;
    logic        chk_dat;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic        g_ack, g_err, m_ack, m_err, w;
    logic [31:0] g_dat, m_dat, a, dt;
    logic [3:0]  s;
    int          lat, ws, sel_kind;

    vt[0]  = '{1'b1, 4'hF, BASE + 32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 4'hF, BASE + 32'h10,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b1};
    vt[2]  = '{1'b1, 4'hF, BASE + 32'h20,  32'h11223344, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 4'h1, BASE + 32'h20,  32'h000000AA, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[4]  = '{1'b1, 4'h4, BASE + 32'h20,  32'h00CC0000, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[5]  = '{1'b0, 4'h1, BASE + 32'h20,  32'h0,        1'b1, 1'b0, 32'h11CC33AA, 1'b1};
    vt[6]  = '{1'b0, 4'hF, BASE + 32'h2,   32'h0,        1'b0, 1'b1, 32'h11CC33AA, 1'b1};
    vt[7]  = '{1'b0, 4'hF, BASE + 32'h100, 32'h0,        1'b0, 1'b1, 32'h11CC33AA, 1'b1};
    vt[8]  = '{1'b1, 4'h0, BASE + 32'h20,  32'hFFFFFFFF, 1'b0, 1'b1, 32'h11CC33AA, 1'b1};
    vt[9]  = '{1'b0, 4'hF, BASE + 32'h20,  32'h0,        1'b1, 1'b0, 32'h11CC33AA, 1'b1};
    vt[10] = '{1'b1, 4'hF, BASE + 32'h13,  32'h12345678, 1'b0, 1'b1, 32'h11CC33AA, 1'b1};
    vt[11] = '{1'b0, 4'hF, BASE + 32'h10,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b1};
    vt[12] = '{1'b0, 4'hF, BASE - 32'h4,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1};

    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = '0; addr[d] = '0; wdat[d] = '0;
    end
    last_dat = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ack", {31'b0, ack[d]}, 32'h0);
      chk("reset_err", {31'b0, err[d]}, 32'h0);
      chk("reset_dat", rdat[d], 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table on the WAIT_STATES=1 instance.
    for (int i = 0; i < 13; i++) begin
      do_req(0, vt[i].we, vt[i].sel, vt[i].addr, vt[i].dat, g_ack, g_err, g_dat, lat);
      model_step(vt[i].we, vt[i].sel, vt[i].addr, vt[i].dat, m_ack, m_err, m_dat);
      chk("vec_ack", {31'b0, g_ack}, {31'b0, vt[i].e_ack});
      chk("vec_err", {31'b0, g_err}, {31'b0, vt[i].e_err});
      chk("vec_latency", 32'(lat), 32'd2);
      if (vt[i].chk_dat) chk("vec_dat", g_dat, vt[i].e_dat);
    end

    // Fill the whole window so random reads have defined contents.
    for (int i = 0; i < WORDS; i++) begin
      dt = $urandom;
      a  = BASE + 32'(4 * i);
      do_req(0, 1'b1, 4'hF, a, dt, g_ack, g_err, g_dat, lat);
      model_step(1'b1, 4'hF, a, dt, m_ack, m_err, m_dat);
      chk("fill_ack", {31'b0, g_ack}, {31'b0, m_ack});
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      w        = 1'($urandom_range(0, 1));
      s        = 4'($urandom_range(0, 15));
      dt       = $urandom;
      sel_kind = int'($urandom_range(0, 9));
      if (sel_kind <= 6)      a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      else if (sel_kind == 7) a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
      else if (sel_kind == 8) a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 1000));
      else                    a = BASE - 32'(4 * $urandom_range(1, 100));
      do_req(0, w, s, a, dt, g_ack, g_err, g_dat, lat);
      model_step(w, s, a, dt, m_ack, m_err, m_dat);
      chk("rnd_ack", {31'b0, g_ack}, {31'b0, m_ack});
      chk("rnd_err", {31'b0, g_err}, {31'b0, m_err});
      chk("rnd_latency", 32'(lat), 32'd2);
      if (!w || m_err) chk("rnd_dat", g_dat, m_dat);
    end

    // Abort: cyc dropped during WAIT, so the write must not land.
    a = BASE + 32'h10;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; addr[0] = a; wdat[0] = ~mem_m[4];
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort_ack", {31'b0, ack[0]}, 32'h0);
      chk("abort_err", {31'b0, err[0]}, 32'h0);
    end
    do_req(0, 1'b0, 4'hF, a, 32'h0, g_ack, g_err, g_dat, lat);
    model_step(1'b0, 4'hF, a, 32'h0, m_ack, m_err, m_dat);
    chk("abort_read_ack", {31'b0, g_ack}, 32'h1);
    chk("abort_read_lat", 32'(lat), 32'd2);
    chk("abort_read_dat", g_dat, m_dat);

    // Reset on the edge that would commit a write.
    a = BASE + 32'h14;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; addr[0] = a; wdat[0] = ~mem_m[5];
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack", {31'b0, ack[0]}, 32'h0);
    chk("rst_mid_err", {31'b0, err[0]}, 32'h0);
    chk("rst_mid_dat", rdat[0], 32'h0);
    rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    last_dat = '0;
    @(posedge clk); #1;
    do_req(0, 1'b0, 4'hF, a, 32'h0, g_ack, g_err, g_dat, lat);
    model_step(1'b0, 4'hF, a, 32'h0, m_ack, m_err, m_dat);
    chk("rst_read_ack", {31'b0, g_ack}, 32'h1);
    chk("rst_read_lat", 32'(lat), 32'd2);
    chk("rst_read_dat", g_dat, m_dat);

    // Latency sweep with WAIT_STATES 0 and 3, and strobe held high continuously.
    for (int d = 1; d < 3; d++) begin
      ws = (d == 1) ? 0 : 3;
      dt = $urandom;
      do_req(d, 1'b1, 4'hF, BASE + 32'h8, dt, g_ack, g_err, g_dat, lat);
      chk("ws_write_ack", {31'b0, g_ack}, 32'h1);
      chk("ws_write_lat", 32'(lat), 32'(ws + 1));
      do_req(d, 1'b0, 4'hF, BASE + 32'h8, 32'h0, g_ack, g_err, g_dat, lat);
      chk("ws_read_ack", {31'b0, g_ack}, 32'h1);
      chk("ws_read_lat", 32'(lat), 32'(ws + 1));
      chk("ws_read_dat", g_dat, dt);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; sel[d] = 4'hF; addr[d] = BASE + 32'h8;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        chk("b2b_ack", {31'b0, ack[d]},
            {31'b0, 1'((k >= ws + 1) && ((k - (ws + 1)) % (ws + 3) == 0))});
        chk("b2b_err", {31'b0, err[d]}, 32'h0);
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
